pixel_stream_source: RTL and testbench

Parametrised raster reader and colour-mode stage between the camera frame buffer and the Avalon-ST video scaler sink.
- Generates frame-buffer read addresses and absorbs the RAM's read latency.
- Applies a per-frame colour mode and emits a 30-bit-class RGB stream with SOP/EOP under a valid/ready handshake.
- Replaces ad-hoc row/col counters and free-running valid; never drops or duplicates pixels when ready stalls.

---
 rtl/pixel_stream_source.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pixel_stream_source.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_source.sv
// Raster read-address generator, colour-mode pipeline and credit-controlled output FIFO.
// Optional colour-bar generator: define PIXEL_STREAM_TEST_PATTERN_EN.
module pixel_stream_source #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned IN_W       = 4,
    parameter int unsigned OUT_W      = 10,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           mode,
    input  logic [OUT_W-1:0]     threshold,
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    input  logic                 pattern_sel,
`endif
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [3*IN_W-1:0]    rd_data,
    output logic [3*OUT_W-1:0]   src_data,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic                 src_sop,
    output logic                 src_eop,
    output logic                 frame_done,
    output logic [2:0]           active_mode
);
    localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
    localparam int unsigned COL_W      = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W      = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned ACC_W      = OUT_W + 9;
    localparam int unsigned BEAT_W     = 3 * OUT_W + 2;

    localparam logic [2:0] ModeGray   = 3'd1;
    localparam logic [2:0] ModeTint   = 3'd2;
    localparam logic [2:0] ModeInvert = 3'd3;
    localparam logic [2:0] ModeThresh = 3'd4;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [2:0] cmode;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        logic       pat;
        logic [2:0] bar;
`endif
    } tag_t;

    function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] c);
        logic [OUT_W-1:0] e;
        for (int i = 0; i < int'(OUT_W); i++) begin
            e[int'(OUT_W) - 1 - i] = c[int'(IN_W) - 1 - (i % int'(IN_W))];
        end
        return e;
    endfunction

    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          active_mode_q, active_mode_d;
    logic                first_px, last_px, issue, pop, push;
    logic [CNT_W:0]      credit_used;
    tag_t                issue_tag, s1_tag;

    logic [RD_LATENCY-1:0] pipe_vld_q;
    tag_t                  pipe_tag_q [RD_LATENCY];

    logic                s2_vld_q, s2_sop_q, s2_eop_q;
    logic [3*OUT_W-1:0]  s2_data_q;

    logic [BEAT_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [BEAT_W-1:0]   fifo_head;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                frame_done_q;

    logic [OUT_W-1:0]    er, eg, eb, gray, tint_p;
    logic [ACC_W-1:0]    gray_acc, tint_acc;
    logic [3*OUT_W-1:0]  conv_data;
    logic                unused_acc;

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    logic                pattern_q, pattern_d;
    logic [2:0]          bar_rgb;
`endif

    assign first_px = (col_q == '0) && (row_q == '0);
    assign last_px  = (col_q == COL_W'(H_RES - 1)) && (row_q == ROW_W'(V_RES - 1));
    assign pop      = src_valid & src_ready;
    assign push     = s2_vld_q;

    // A pop this cycle frees a slot long before any newly issued read can land.
    always_comb begin
        credit_used = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(s2_vld_q);
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            credit_used = credit_used + (CNT_W + 1)'(pipe_vld_q[i]);
        end
    end
    assign issue = credit_used < ((CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop));

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        active_mode_d = active_mode_q;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        pattern_d     = pattern_q;
`endif
        if (issue) begin
            if (first_px) begin
                active_mode_d = mode;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
                pattern_d     = pattern_sel;
`endif
            end
            if (col_q == COL_W'(H_RES - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(V_RES - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            addr_d = last_px ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.sop   = first_px;
        issue_tag.eop   = last_px;
        issue_tag.cmode = first_px ? mode : active_mode_q;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        issue_tag.pat   = first_px ? pattern_sel : pattern_q;
        issue_tag.bar   = 3'({col_q, 3'b000} / (COL_W + 3)'(H_RES));
`endif
    end

    assign s1_tag = pipe_tag_q[RD_LATENCY-1];

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    always_comb begin
        case (s1_tag.bar)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end
`endif

    always_comb begin
        er = expand(rd_data[3*IN_W-1 -: IN_W]);
        eg = expand(rd_data[2*IN_W-1 -: IN_W]);
        eb = expand(rd_data[IN_W-1:0]);
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        if (s1_tag.pat) begin
            er = {OUT_W{bar_rgb[2]}};
            eg = {OUT_W{bar_rgb[1]}};
            eb = {OUT_W{bar_rgb[0]}};
        end
`endif
        gray_acc = ACC_W'(77) * ACC_W'(er) + ACC_W'(150) * ACC_W'(eg)
                 + ACC_W'(29) * ACC_W'(eb);
        tint_acc = ACC_W'(120) * ACC_W'(er) + ACC_W'(60) * ACC_W'(eg)
                 + ACC_W'(50) * ACC_W'(eb);
        gray     = gray_acc[8 +: OUT_W];
        tint_p   = tint_acc[8 +: OUT_W];
        case (s1_tag.cmode)
            ModeGray:   conv_data = {gray, gray, gray};
            ModeTint:   conv_data = {tint_p, tint_p >> 2, tint_p >> 1};
            ModeInvert: conv_data = {~er, ~eg, ~eb};
            ModeThresh: conv_data = (gray >= threshold) ? '1 : '0;
            default:    conv_data = {er, eg, eb};
        endcase
    end

    assign unused_acc = ^{gray_acc[7:0], gray_acc[ACC_W-1], tint_acc[7:0], tint_acc[ACC_W-1]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            active_mode_q <= '0;
            pipe_vld_q    <= '0;
            s2_vld_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_done_q  <= 1'b0;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
            pattern_q     <= 1'b0;
`endif
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            active_mode_q <= active_mode_d;
            pipe_vld_q[0] <= issue;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
            s2_vld_q      <= pipe_vld_q[RD_LATENCY-1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_done_q  <= pop & src_eop;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
            pattern_q     <= pattern_d;
`endif
        end
    end

    // Payload registers carry no reset; their valid bits above qualify them.
    always_ff @(posedge clk) begin
        pipe_tag_q[0] <= issue_tag;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
        end
        if (pipe_vld_q[RD_LATENCY-1]) begin
            s2_data_q <= conv_data;
            s2_sop_q  <= s1_tag.sop;
            s2_eop_q  <= s1_tag.eop;
        end
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {s2_sop_q, s2_eop_q, s2_data_q};
        end
    end

    assign fifo_head   = fifo_mem_q[rd_ptr_q];
    assign src_valid   = (count_q != '0);
    assign src_data    = fifo_head[3*OUT_W-1:0];
    assign src_sop     = src_valid & fifo_head[3*OUT_W+1];
    assign src_eop     = src_valid & fifo_head[3*OUT_W];
    assign frame_done  = frame_done_q;
    assign active_mode = active_mode_q;
    assign rd_addr     = addr_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source on a reduced 16x8 raster with a 2-cycle RAM model.
module tb_pixel_stream_source;
    localparam int unsigned L  = 2;
    localparam int unsigned H  = 16;
    localparam int unsigned V  = 8;
    localparam int unsigned N  = H * V;
    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    mode;
    logic [9:0]    threshold;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic [29:0]   src_data;
    logic          src_valid, src_ready, src_sop, src_eop, frame_done;
    logic [2:0]    active_mode;

    logic [1:0]    ram_kind;
    logic [AW-1:0] apipe [L];

    int total = 0;
    int bad   = 0;

    // Scoreboard state
    int          k;
    logic        fd_exp;
    logic        prev_stall;
    logic [32:0] prev_beat;
    logic [AW-1:0] prev_rd_addr;
    logic [2:0]  mode_prev, sb_mode, sb_next_mode;

    pixel_stream_source #(
        .H_RES(H), .V_RES(V), .IN_W(4), .OUT_W(10), .ADDR_W(AW), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .threshold(threshold),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop), .frame_done(frame_done),
        .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        apipe[0] <= rd_addr;
        for (int i = 1; i < int'(L); i++) apipe[i] <= apipe[i-1];
    end

    always_comb begin
        rd_data = apipe[L-1][11:0];
        case (ram_kind)
            2'd1:    rd_data = 12'hF00;
            2'd2:    rd_data = (apipe[L-1] == '0) ? 12'h888 : 12'h777;
            default: rd_data = apipe[L-1][11:0];
        endcase
    end

    function automatic logic [9:0] ex4(input logic [3:0] c);
        return {c, c, c[3:2]};
    endfunction

    function automatic logic [29:0] model(input logic [2:0] m, input logic [11:0] d,
                                          input logic [9:0] thr);
        logic [9:0] r, g, b, gy, tp;
        r  = ex4(d[11:8]);
        g  = ex4(d[7:4]);
        b  = ex4(d[3:0]);
        gy = 10'((77 * int'(r) + 150 * int'(g) + 29 * int'(b)) / 256);
        tp = 10'((120 * int'(r) + 60 * int'(g) + 50 * int'(b)) / 256);
        case (m)
            3'd1:    return {gy, gy, gy};
            3'd2:    return {tp, tp >> 2, tp >> 1};
            3'd3:    return {10'd1023 - r, 10'd1023 - g, 10'd1023 - b};
            3'd4:    return (gy >= thr) ? {30{1'b1}} : 30'd0;
            default: return {r, g, b};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset     = 1'b1;
        src_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_valid", 64'(src_valid), 64'd0);
        check("rst_sop_eop", 64'({src_sop, src_eop}), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_active_mode", 64'(active_mode), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
    endtask

    // First beat must appear exactly L+2 cycles after reset is released.
    task automatic release_check();
        reset = 1'b0;
        for (int c = 1; c <= int'(L) + 2; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) check("active_mode_latch", 64'(active_mode), 64'(mode));
            check("first_latency", 64'(src_valid), 64'(c == int'(L) + 2));
        end
        check("first_sop", 64'(src_sop), 64'd1);
        k            = 0;
        fd_exp       = 1'b0;
        prev_stall   = 1'b0;
        prev_rd_addr = rd_addr;
        mode_prev    = mode;
        sb_mode      = mode;
        sb_next_mode = mode;
    endtask

    task automatic run(input int target, input bit rnd, input bit contig);
        int   cyc = 0;
        int   budget = 8 * target + 64;
        int   a;
        logic fd_next;
        while (k < target && cyc < budget) begin
            src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("frame_done", 64'(frame_done), 64'(fd_exp));
            if (prev_stall)
                check("stall_hold", 64'({src_valid, src_sop, src_eop, src_data}), 64'(prev_beat));
            if (contig && k > 0) check("contiguous", 64'(src_valid), 64'd1);
            fd_next = 1'b0;
            if (src_valid && src_ready) begin
                a = k % int'(N);
                if (a == 0 && k > 0) sb_mode = sb_next_mode;
                check("beat", 64'({src_sop, src_eop, src_data}),
                      64'({a == 0, a == int'(N) - 1, model(sb_mode, 12'(a), threshold)}));
                if (a == int'(N) - 1) fd_next = 1'b1;
                k++;
            end
            if (rd_addr == AW'(1) && prev_rd_addr == '0)
                check("active_mode_issue", 64'(active_mode), 64'(mode_prev));
            prev_rd_addr = rd_addr;
            mode_prev    = mode;
            prev_stall   = src_valid && !src_ready;
            prev_beat    = {src_valid, src_sop, src_eop, src_data};
            @(posedge clk);
            #1;
            fd_exp = fd_next;
            cyc++;
        end
        if (k < target) check("cycle_budget", 64'(k), 64'(target));
    endtask

    task automatic two_beats(input string tag, input logic [29:0] e0, input logic [29:0] e1);
        apply_reset(2);
        release_check();
        check({tag, "_b0"}, 64'(src_data), 64'(e0));
        @(posedge clk);
        #1;
        check({tag, "_b1"}, 64'({src_valid, src_data}), 64'({1'b1, e1}));
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 3'd0;
        threshold = 10'd0;
        ram_kind  = 2'd0;
        src_ready = 1'b1;

        // Full frame, ready high: contiguous beats, one EOP, one frame_done
        apply_reset(3);
        release_check();
        run(int'(N) + 1, 1'b0, 1'b1);

        // Random backpressure over two frames
        apply_reset(2);
        release_check();
        run(2 * int'(N), 1'b1, 1'b0);

        // Mode change mid-frame only takes effect at the next frame
        mode = 3'd0;
        apply_reset(2);
        release_check();
        run(40, 1'b0, 1'b1);
        mode         = 3'd1;
        sb_next_mode = 3'd1;
        run(41, 1'b0, 1'b1);
        check("mode_hold_midframe", 64'(active_mode), 64'd0);
        run(int'(N) + 20, 1'b0, 1'b1);
        check("mode_new_frame", 64'(active_mode), 64'd1);

        // Reset mid-frame discards in-flight pixels and restarts at (0,0)
        mode = 3'd0;
        apply_reset(2);
        release_check();
        run(51, 1'b0, 1'b1);
        apply_reset(1);
        release_check();
        run(int'(N) + 1, 1'b0, 1'b1);

        // Reset coinciding with the EOP handshake suppresses frame_done
        apply_reset(2);
        release_check();
        run(int'(N) - 1, 1'b0, 1'b1);
        check("eop_pending", 64'({src_valid, src_eop}), 64'(2'b11));
        apply_reset(1);
        release_check();

        // Colour modes on constant 12'hF00 (R expands to 1023)
        ram_kind = 2'd1;
        mode = 3'd1;
        two_beats("gray", {10'd307, 10'd307, 10'd307}, {10'd307, 10'd307, 10'd307});
        mode = 3'd2;
        two_beats("tint", {10'd479, 10'd119, 10'd239}, {10'd479, 10'd119, 10'd239});
        mode = 3'd3;
        two_beats("invert", {10'd0, 10'd1023, 10'd1023}, {10'd0, 10'd1023, 10'd1023});
        mode = 3'd5;
        two_beats("mode5_pass", {10'd1023, 10'd0, 10'd0}, {10'd1023, 10'd0, 10'd0});

        // 12'h888 at address 0, 12'h777 elsewhere: gray 546 then 477
        ram_kind = 2'd2;
        mode = 3'd0;
        two_beats("pass_888_777", {10'd546, 10'd546, 10'd546}, {10'd477, 10'd477, 10'd477});
        mode = 3'd4;
        threshold = 10'd512;
        two_beats("thr512", {30{1'b1}}, 30'd0);
        threshold = 10'd546;
        two_beats("thr_equal", {30{1'b1}}, 30'd0);
        threshold = 10'd0;
        two_beats("thr_zero", {30{1'b1}}, {30{1'b1}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
